configurable_switch_box: RTL and testbench
==========================================

# configurable_switch_box

Synthesizable, unidirectional successor to the bidirectional fabric switch box. Each side has separate input/output buses for single, double and global tracks. Output-track routing comes from an internal configuration register loaded over a serial scan chain, with a shadow/active double buffer. Each side can optionally register its outputs to pipeline long routes. The block sits at every tile corner; the scan chains are daisy-chained through the fabric.

## Interface
- WS, 8: single tracks per side
- WD, 8: double tracks per side; must be even
- WG, 3: global tracks per side
- CW (localparam) = 8*WS + 4*WD + 4: configuration bits (100 at defaults)

- clk  input  1  fabric clock; only clock
- rst_n  input  1  synchronous, active-low reset
- cfg_en  input  1  shift enable for scan chain
- cfg_in  input  1  scan data in
- cfg_commit  input  1  one-cycle pulse: copy shadow to active
- cfg_out  output  1  scan data out = shadow[0]
- cfg_done  output  1  high when shift count == CW
- cfg_err  output  1  sticky: commit attempted with count != CW
- {north,east,south,west}_single_in  input  WS each  single tracks entering
- {north,east,south,west}_single_out  output  WS each  single tracks leaving
- {north,east,south,west}_double_in  input  WD each
- {north,east,south,west}_double_out  output  WD each
- {north,east,south,west}_global_in  input  WG each
- {north,east,south,west}_global_out  output  WG each

## Operation
- Side index S: N=0, E=1, S=2, W=3.
- Source select code for an output on side X:
  - 00: drive 0.
  - 01: clockwise neighbour (N<-E, E<-S, S<-W, W<-N).
  - 10: opposite side.
  - 11: counter-clockwise neighbour (N<-W, E<-N, S<-E, W<-S).
- Singles: X_single_out[i] selects source side's single_in[i]. Select field is active[2*(S*WS+i)+1 : 2*(S*WS+i)].
- Doubles, j < WD/2:
  - X_double_out[j] selects source side's double_in[j+WD/2]. Field is active[8*WS + 2*(S*WD/2+j) +: 2].
  - X_double_out[j+WD/2] = opposite side's double_in[j], unconditional stagger pass-through.
- Globals: X_global_out[k] = opposite side's global_in[k], unconditional.
- Register bit active[CW-4+S]:
  - 1: every output of side S (single, double, global) comes from a flop loaded each cycle with the combinational value.
  - 0: output is combinational.
- Scan chain, when cfg_en is high:
  - shadow <= {cfg_in, shadow[CW-1:1]}, LSB-first: the first bit shifted lands in bit 0 after CW shifts.
  - count increments and saturates at CW. Shifting continues past CW, so the last CW bits win.
- Commit rules:
  - cfg_commit with count == CW: active <= shadow (pre-shift value if cfg_en is also high), then count <= (cfg_en ? 1 : 0).
  - cfg_commit with count != CW: active unchanged, count unaffected, cfg_err <= 1.
- Reset (rst_n low at clk edge): shadow, active, count, output flops and cfg_err all go to 0.
  - Result: every switched output drives 0, all sides are combinational, pass-throughs stay active.
- Reset overrides cfg_en and cfg_commit in the same cycle.

## Timing
- Combinational path from *_in to *_out for unregistered sides.
- Registered sides: 1-cycle latency, value sampled at the clk edge.
- Flops update every cycle regardless of cfg activity.
- cfg_out: shadow[0]; changes on the edge after each shift.
- cfg_done: combinational from count; high the cycle after the CW-th shift.
- Commit at edge k: the new active value drives muxes immediately after edge k.
  - A side switching to registered mode at edge k outputs the flop value. That flop holds the value sampled at edge k under the old routing; the new routing appears at edge k+1.
- Reset values: cfg_out=0, cfg_done=0, cfg_err=0. Switched outputs are 0. Pass-through outputs follow their inputs.

## Test plan
- Reset, then drive north_single_in=8'hA5 and every single_in=8'hFF -> all *_single_out=0 and cfg_done=0. south_double_out[7:4] follows north_double_in[3:0]; east_global_out=west_global_in.
- Shift 100 bits setting north single selects to 10 (opposite) and all others 00, then commit; drive south_single_in=8'h3C -> same cycle north_single_out=8'h3C, cfg_done drops to 0, cfg_err=0.
- Commit after only 50 shifts -> active unchanged (outputs stay 0), cfg_err=1 and stays 1 until rst_n low.
- Config with east double_out[1] select=11 and east register bit=1; toggle north_double_in[5] 0->1 at edge k -> east_double_out[1] rises one edge later (k+1).
- Shift 150 bits -> cfg_done=1 and active = last 100 bits. cfg_out stream reproduces the bits shifted in 100 cycles earlier.
- Assert cfg_en and cfg_commit together with count==100 -> active takes the pre-shift shadow, and count reads 1 next cycle. Assert rst_n low mid-shift -> count=0 and outputs=0 next cycle.

Source files
------------

// File: rtl/configurable_switch_box.sv
// Unidirectional fabric switch box. Single and double outputs are routed by
// 2-bit select fields in a double-buffered (shadow/active) configuration
// register loaded over a serial scan chain. Globals and the upper half of the
// double tracks are fixed pass-throughs from the opposite side. Each side can
// register its outputs to pipeline long routes.
module configurable_switch_box #(
    parameter int WS = 8,
    parameter int WD = 8,   // must be even: lower half switched, upper half staggered
    parameter int WG = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_en,
    input  logic          cfg_in,
    input  logic          cfg_commit,
    output logic          cfg_out,
    output logic          cfg_done,
    output logic          cfg_err,
    input  logic [WS-1:0] north_single_in,
    input  logic [WS-1:0] east_single_in,
    input  logic [WS-1:0] south_single_in,
    input  logic [WS-1:0] west_single_in,
    output logic [WS-1:0] north_single_out,
    output logic [WS-1:0] east_single_out,
    output logic [WS-1:0] south_single_out,
    output logic [WS-1:0] west_single_out,
    input  logic [WD-1:0] north_double_in,
    input  logic [WD-1:0] east_double_in,
    input  logic [WD-1:0] south_double_in,
    input  logic [WD-1:0] west_double_in,
    output logic [WD-1:0] north_double_out,
    output logic [WD-1:0] east_double_out,
    output logic [WD-1:0] south_double_out,
    output logic [WD-1:0] west_double_out,
    input  logic [WG-1:0] north_global_in,
    input  logic [WG-1:0] east_global_in,
    input  logic [WG-1:0] south_global_in,
    input  logic [WG-1:0] west_global_in,
    output logic [WG-1:0] north_global_out,
    output logic [WG-1:0] east_global_out,
    output logic [WG-1:0] south_global_out,
    output logic [WG-1:0] west_global_out
);

    localparam int CW   = 8*WS + 4*WD + 4;
    localparam int HD   = WD / 2;
    localparam int CNTW = $clog2(CW + 1);
    localparam int DOFS = 8*WS;     // start of double select fields
    localparam int ROFS = CW - 4;   // start of per-side register-enable bits

    logic [CW-1:0]   shadow;
    logic [CW-1:0]   active;
    logic [CNTW-1:0] count;
    logic            commit_ok;

    // Side-indexed views: 0=N, 1=E, 2=S, 3=W
    logic [WS-1:0] s_in [4];
    logic [WS-1:0] s_comb [4];
    logic [WS-1:0] s_q [4];
    logic [WS-1:0] s_out [4];
    logic [WD-1:0] d_in [4];
    logic [WD-1:0] d_comb [4];
    logic [WD-1:0] d_q [4];
    logic [WD-1:0] d_out [4];
    logic [WG-1:0] g_in [4];
    logic [WG-1:0] g_comb [4];
    logic [WG-1:0] g_q [4];
    logic [WG-1:0] g_out [4];

    // Select code k picks side (S+k) mod 4: 01 clockwise, 10 opposite, 11 ccw.
    function automatic logic [1:0] src_side(input int side, input logic [1:0] code);
        return 2'(side) + code;
    endfunction

    assign s_in[0] = north_single_in;
    assign s_in[1] = east_single_in;
    assign s_in[2] = south_single_in;
    assign s_in[3] = west_single_in;
    assign d_in[0] = north_double_in;
    assign d_in[1] = east_double_in;
    assign d_in[2] = south_double_in;
    assign d_in[3] = west_double_in;
    assign g_in[0] = north_global_in;
    assign g_in[1] = east_global_in;
    assign g_in[2] = south_global_in;
    assign g_in[3] = west_global_in;

    assign north_single_out = s_out[0];
    assign east_single_out  = s_out[1];
    assign south_single_out = s_out[2];
    assign west_single_out  = s_out[3];
    assign north_double_out = d_out[0];
    assign east_double_out  = d_out[1];
    assign south_double_out = d_out[2];
    assign west_double_out  = d_out[3];
    assign north_global_out = g_out[0];
    assign east_global_out  = g_out[1];
    assign south_global_out = g_out[2];
    assign west_global_out  = g_out[3];

    assign commit_ok = cfg_commit && (count == CNTW'(CW));
    assign cfg_done  = (count == CNTW'(CW));
    assign cfg_out   = shadow[0];

    // Scan chain, shift counter, shadow-to-active commit and sticky error.
    // A good commit with a simultaneous shift captures the pre-shift shadow
    // and counts that shift as the first bit of the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            count   <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (cfg_en) begin
                shadow <= {cfg_in, shadow[CW-1:1]};
            end
            if (commit_ok) begin
                active <= shadow;
                count  <= cfg_en ? CNTW'(1) : '0;
            end else if (cfg_en && (count != CNTW'(CW))) begin
                count <= count + CNTW'(1);
            end
            if (cfg_commit && !commit_ok) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Routing muxes: switched singles/lower doubles, fixed stagger and globals.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            s_comb[s] = '0;
            d_comb[s] = '0;
            g_comb[s] = g_in[src_side(s, 2'b10)];
            for (int i = 0; i < WS; i++) begin
                if (active[2*(s*WS+i) +: 2] != 2'b00) begin
                    s_comb[s][i] = s_in[src_side(s, active[2*(s*WS+i) +: 2])][i];
                end
            end
            for (int j = 0; j < HD; j++) begin
                if (active[DOFS + 2*(s*HD+j) +: 2] != 2'b00) begin
                    d_comb[s][j] = d_in[src_side(s, active[DOFS + 2*(s*HD+j) +: 2])][j+HD];
                end
                d_comb[s][j+HD] = d_in[src_side(s, 2'b10)][j];
            end
        end
    end

    // Pipeline flops sample the routed value every cycle, whatever the mode.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (!rst_n) begin
                s_q[s] <= '0;
                d_q[s] <= '0;
                g_q[s] <= '0;
            end else begin
                s_q[s] <= s_comb[s];
                d_q[s] <= d_comb[s];
                g_q[s] <= g_comb[s];
            end
        end
    end

    // Per-side choice between registered and combinational outputs.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            s_out[s] = active[ROFS+s] ? s_q[s] : s_comb[s];
            d_out[s] = active[ROFS+s] ? d_q[s] : d_comb[s];
            g_out[s] = active[ROFS+s] ? g_q[s] : g_comb[s];
        end
    end

endmodule

// File: tb/tb_configurable_switch_box.sv
// Directed bench for configurable_switch_box: expectations are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_configurable_switch_box;

    localparam int WS = 8;
    localparam int WD = 8;
    localparam int WG = 3;
    localparam int CW = 8*WS + 4*WD + 4;
    localparam int HD = WD / 2;

    logic clk = 1'b0;
    logic rst_n, cfg_en, cfg_in, cfg_commit;
    logic cfg_out, cfg_done, cfg_err;
    logic [WS-1:0] north_single_in, east_single_in, south_single_in, west_single_in;
    logic [WS-1:0] north_single_out, east_single_out, south_single_out, west_single_out;
    logic [WD-1:0] north_double_in, east_double_in, south_double_in, west_double_in;
    logic [WD-1:0] north_double_out, east_double_out, south_double_out, west_double_out;
    logic [WG-1:0] north_global_in, east_global_in, south_global_in, west_global_in;
    logic [WG-1:0] north_global_out, east_global_out, south_global_out, west_global_out;

    int tests = 0;
    int fails = 0;
    string       q_tag [$];
    logic [31:0] q_val [$];

    logic [CW-1:0]   cfg_a, cfg_b, cfg_c;
    logic [CW+49:0]  stream;

    configurable_switch_box #(.WS(WS), .WD(WD), .WG(WG)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in),
        .cfg_commit(cfg_commit), .cfg_out(cfg_out), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .north_single_in(north_single_in), .east_single_in(east_single_in),
        .south_single_in(south_single_in), .west_single_in(west_single_in),
        .north_single_out(north_single_out), .east_single_out(east_single_out),
        .south_single_out(south_single_out), .west_single_out(west_single_out),
        .north_double_in(north_double_in), .east_double_in(east_double_in),
        .south_double_in(south_double_in), .west_double_in(west_double_in),
        .north_double_out(north_double_out), .east_double_out(east_double_out),
        .south_double_out(south_double_out), .west_double_out(west_double_out),
        .north_global_in(north_global_in), .east_global_in(east_global_in),
        .south_global_in(south_global_in), .west_global_in(west_global_in),
        .north_global_out(north_global_out), .east_global_out(east_global_out),
        .south_global_out(south_global_out), .west_global_out(west_global_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        q_tag.push_back(tag);
        q_val.push_back(val);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] expv;
        tests++;
        if (q_val.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_underflow observed=%0h expected=<none>", obs);
            return;
        end
        tag  = q_tag.pop_front();
        expv = q_val.pop_front();
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic shift_vec(input logic [CW-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_en = 1'b1;
            cfg_in = v[i];
            tick();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
        north_single_in = 8'hA5; east_single_in = 8'hFF;
        south_single_in = 8'hFF; west_single_in = 8'hFF;
        north_double_in = 8'h3A; east_double_in = 8'h00;
        south_double_in = 8'hC5; west_double_in = 8'h96;
        north_global_in = 3'b000; east_global_in = 3'b000;
        south_global_in = 3'b000; west_global_in = 3'b101;

        // Configuration images
        cfg_a = '0;
        for (int i = 0; i < WS; i++) cfg_a[2*i +: 2] = 2'b10;             // north singles <- south
        cfg_b = '0;
        cfg_b[8*WS + 2*(1*HD + 1) +: 2] = 2'b11;                          // east double[1] <- north
        cfg_b[CW-4+1] = 1'b1;                                             // east registered
        cfg_c = '0;
        for (int i = 0; i < WS; i++) cfg_c[2*(3*WS + i) +: 2] = 2'b01;    // west singles <- north
        stream = {cfg_c, 50'h3_FFFF_FFFF_FFFF};

        // Reset state
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push("rst_singles", 0);
        check({north_single_out, east_single_out, south_single_out, west_single_out});
        push("rst_cfg_done", 0);      check(32'(cfg_done));
        push("rst_cfg_err", 0);       check(32'(cfg_err));
        push("rst_cfg_out", 0);       check(32'(cfg_out));
        push("rst_s_dbl_stagger", 'hA); check(32'(south_double_out[7:4]));
        push("rst_n_dbl", 'h50);      check(32'(north_double_out));
        push("rst_e_global", 'b101);  check(32'(east_global_out));

        // Load north-from-opposite config, done boundary at exactly CW shifts
        shift_vec(cfg_a, CW - 1);
        push("done_at_cw_minus_1", 0); check(32'(cfg_done));
        shift_vec(cfg_a >> (CW - 1), 1);
        push("done_at_cw", 1);         check(32'(cfg_done));
        push("no_route_before_commit", 0); check(32'(north_single_out));
        commit();
        south_single_in = 8'h3C;
        #1;
        push("n_single_opposite", 'h3C); check(32'(north_single_out));
        push("e_single_unrouted", 0);    check(32'(east_single_out));
        push("done_after_commit", 0);    check(32'(cfg_done));
        push("err_after_good_commit", 0); check(32'(cfg_err));

        // Short load then commit: rejected, sticky error
        shift_vec('1, 50);
        commit();
        push("short_commit_keeps_n", 'h3C); check(32'(north_single_out));
        push("short_commit_keeps_w", 0);    check(32'(west_single_out));
        push("short_commit_err", 1);        check(32'(cfg_err));
        repeat (5) tick();
        push("err_sticky", 1);              check(32'(cfg_err));

        // East double[1] from north double[5], east side registered
        shift_vec(cfg_b, CW);
        push("done_after_saturate", 1); check(32'(cfg_done));
        commit();
        push("cfg_b_n_single", 0);      check(32'(north_single_out));
        north_double_in = 8'h1A;
        repeat (2) tick();
        push("pipe_low", 0);            check(32'(east_double_out[1]));
        north_double_in = 8'h3A;
        west_global_in  = 3'b010;
        push("pipe_not_comb", 0);
        push("pipe_glb_old", 'b101);
        push("pipe_rise_k1", 1);
        push("pipe_glb_new", 'b010);
        #1;
        check(32'(east_double_out[1]));
        check(32'(east_global_out));
        tick();
        check(32'(east_double_out[1]));
        check(32'(east_global_out));
        push("err_still_set", 1);       check(32'(cfg_err));

        // 150-bit stream: cfg_out echoes bits from CW shifts earlier
        for (int n = 1; n <= CW + 50; n++) begin
            cfg_en = 1'b1;
            cfg_in = stream[n-1];
            if (n >= CW) push("cfg_out_stream", 32'(stream[n-CW]));
            tick();
            if (n >= CW) check(32'(cfg_out));
        end
        push("done_after_150", 1); check(32'(cfg_done));

        // Commit while shifting: pre-shift shadow wins, count restarts at 1
        cfg_in = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_en = 1'b0;
        cfg_commit = 1'b0;
        push("w_single_cw", 'hA5);        check(32'(west_single_out));
        push("n_single_cfg_c", 0);        check(32'(north_single_out));
        push("e_double_comb", 'h60);      check(32'(east_double_out));
        push("e_global_comb", 'b010);     check(32'(east_global_out));
        push("done_after_shift_commit", 0); check(32'(cfg_done));
        shift_vec('0, CW - 2);
        push("count_from_1_not_done", 0); check(32'(cfg_done));
        shift_vec('0, 1);
        push("count_from_1_done", 1);     check(32'(cfg_done));

        // Reset in the middle of a shift with a commit pending
        shift_vec('1, 30);
        cfg_en = 1'b1; cfg_in = 1'b1; cfg_commit = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; cfg_en = 1'b0; cfg_commit = 1'b0;
        push("midrst_singles", 0);
        check({north_single_out, east_single_out, south_single_out, west_single_out});
        push("midrst_done", 0);        check(32'(cfg_done));
        push("midrst_err", 0);         check(32'(cfg_err));
        push("midrst_cfg_out", 0);     check(32'(cfg_out));
        push("midrst_s_dbl", 'hA0);    check(32'(south_double_out));
        shift_vec('1, CW - 1);
        push("midrst_count0_not_done", 0); check(32'(cfg_done));
        shift_vec('1, 1);
        push("midrst_count0_done", 1);     check(32'(cfg_done));

        tests++;
        assert (q_val.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", q_val.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
